// File: rtl/alu_arbiter_pkg.sv
// alu_arbiter_pkg: shared width default, FSM encoding and ALU op constants
package alu_arbiter_pkg;
    localparam int WIDTH_DEFAULT = 16;
    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
endpackage

// File: rtl/rr_arbiter2.sv
// rr_arbiter2: two-way round-robin grant, requester 0 wins the first tie after reset
module rr_arbiter2 (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       enable,
    output logic [1:0] grant
);
    logic last_grant;
    always_comb grant = !enable ? 2'b00 : (req == 2'b11) ? (last_grant ? 2'b01 : 2'b10) : req;
    always_ff @(posedge clk) begin
        if (reset) last_grant <= 1'b1;
        else if (|grant) last_grant <= grant[1];
    end
endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one external ALU between two requesters, one transaction in flight
module alu_arbiter
    import alu_arbiter_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0_valid,
    input  logic             req1_valid,
    output logic             req0_ready,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req0_srca,
    input  logic [WIDTH-1:0] req0_srcb,
    input  logic [WIDTH-1:0] req1_srca,
    input  logic [WIDTH-1:0] req1_srcb,
    input  logic             req0_op,
    input  logic             req1_op,
    output logic [WIDTH-1:0] alu_srca,
    output logic [WIDTH-1:0] alu_srcb,
    output logic             alu_op,
    input  logic [WIDTH-1:0] alu_out,
    input  logic             alu_zero,
    output logic             rsp0_valid,
    output logic             rsp1_valid,
    input  logic             rsp0_ready,
    input  logic             rsp1_ready,
    output logic [WIDTH-1:0] rsp_out,
    output logic             rsp_zero
);
    state_t state, state_nx;
    logic id, op, done;
    logic [WIDTH-1:0] srca, srcb;
    logic [1:0] grant;

    rr_arbiter2 u_arb (
        .clk    (clk),
        .reset  (reset),
        .req    ({req1_valid, req0_valid}),
        .enable (state == IDLE && !reset),
        .grant  (grant)
    );

    always_comb begin
        req0_ready = grant[0];
        req1_ready = grant[1];
        rsp0_valid = state == RESP && !id && !reset;
        rsp1_valid = state == RESP && id && !reset;
        alu_srca   = srca;
        alu_srcb   = srcb;
        alu_op     = op;
        done       = id ? rsp1_ready : rsp0_ready;
        state_nx   = state;
        if (state == IDLE && |grant) state_nx = EXEC;
        else if (state == EXEC) state_nx = RESP;
        else if (state == RESP && done) state_nx = IDLE;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            id       <= 1'b0;
            srca     <= '0;
            srcb     <= '0;
            op       <= OP_ADD;
            rsp_out  <= '0;
            rsp_zero <= 1'b0;
        end else begin
            state <= state_nx;
            if (|grant) begin
                id   <= grant[1];
                srca <= grant[1] ? req1_srca : req0_srca;
                srcb <= grant[1] ? req1_srcb : req0_srcb;
                op   <= grant[1] ? req1_op : req0_op;
            end
            if (state == EXEC) begin
                rsp_out  <= alu_out;
                rsp_zero <= alu_zero;
            end
        end
    end
endmodule
